// File: rtl/seg_display_arbiter_if.sv
// Request/acknowledge bundle between the four display sources and the arbiter.
// Source i owns req[i] and req_data[32i+31:32i]; ack is one-hot.
interface seg_display_arbiter_if;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   ack;

    modport master (output req, output req_data, input ack);
    modport slave  (input req, input req_data, output ack);
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 32-bit seven-segment display among four sources,
// holding each latched value for at least HOLD_CYCLES cycles before re-arbitrating.
module seg_display_arbiter #(
    parameter logic [31:0] HOLD_CYCLES = 32'd100_000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_arbiter_if.slave  bus,
    output logic [31:0]           disp_data,
    output logic                  disp_valid,
    output logic [1:0]            disp_src,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  rr_last_q, rr_last_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] disp_data_q, disp_data_d;
    logic        disp_valid_q, disp_valid_d;
    logic [1:0]  disp_src_q, disp_src_d;
    logic        busy_q, busy_d;
    logic [1:0]  winner;
    logic [3:0]  ack;

    // Scan from farthest to nearest so the index right after last ends up winning.
    function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] w;
        logic [1:0] idx;
        w = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (r[idx]) begin
                w = idx;
            end
        end
        return w;
    endfunction

    always_comb begin
        winner = pick_winner(bus.req, rr_last_q);
    end

    always_comb begin
        ack = 4'b0000;
        if (state_q == LOAD && bus.req[sel_q]) begin
            ack[sel_q] = 1'b1;
        end
    end

    assign bus.ack = ack;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rr_last_d    = rr_last_q;
        cnt_d        = cnt_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        disp_src_d   = disp_src_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    sel_d   = winner;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // A request withdrawn during LOAD is dropped without touching the display.
                if (bus.req[sel_q]) begin
                    disp_data_d  = bus.req_data[32*sel_q +: 32];
                    disp_src_d   = sel_q;
                    disp_valid_d = 1'b1;
                    rr_last_d    = sel_q;
                    cnt_d        = HOLD_CYCLES - 32'd1;
                    state_d      = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (|bus.req) begin
                    sel_d   = winner;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 2'd0;
            rr_last_q    <= 2'd3;
            cnt_q        <= 32'd0;
            disp_data_q  <= 32'd0;
            disp_valid_q <= 1'b0;
            disp_src_q   <= 2'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rr_last_q    <= rr_last_d;
            cnt_q        <= cnt_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            disp_src_q   <= disp_src_d;
            busy_q       <= busy_d;
        end
    end

    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign disp_src   = disp_src_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with HOLD_CYCLES=4: a vector table for
// reset and single-source service, then sequences for contention, abort, dwell and reset mid-HOLD.
module tb_seg_display_arbiter;

    localparam logic [31:0] D0 = 32'hCAFE_0000;
    localparam logic [31:0] D1 = 32'h1111_2222;
    localparam logic [31:0] D2 = 32'h1234_5678;
    localparam logic [31:0] D3 = 32'h3333_4444;

    logic        clk;
    logic        rst;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic [1:0]  disp_src;
    logic        busy;

    int compared;
    int mismatched;

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(.HOLD_CYCLES(32'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_src   (disp_src),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  ack;
        logic [31:0] data;
        logic        valid;
        logic [1:0]  src;
        logic        busy;
    } vec_t;

    vec_t vecs [15];

    // Drives inputs just after a rising edge so the next edge samples them.
    task automatic applyStimulus(input logic r, input logic [3:0] q);
        @(posedge clk);
        #1;
        rst     = r;
        bus.req = q;
    endtask

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_ack, input logic [31:0] e_data,
                               input logic e_valid, input logic [1:0] e_src, input logic e_busy);
        @(negedge clk);
        compareField({name, ".ack"},   32'(bus.ack),    32'(e_ack));
        compareField({name, ".data"},  disp_data,       e_data);
        compareField({name, ".valid"}, 32'(disp_valid), 32'(e_valid));
        compareField({name, ".src"},   32'(disp_src),   32'(e_src));
        compareField({name, ".busy"},  32'(busy),       32'(e_busy));
    endtask

    initial begin
        logic [1:0]  order [7];
        logic [31:0] dmap [4];
        int          g_done;
        logic [3:0]  e_ack;
        logic [31:0] e_data;
        logic [1:0]  e_src;

        compared   = 0;
        mismatched = 0;
        rst          = 1'b1;
        bus.req      = 4'b1111;
        bus.req_data = {D3, D2, D1, D0};

        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 32'h0, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 32'h0, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 32'h0, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0001, 32'h0, 1'b0, 2'd0, 1'b1};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, D0,    1'b1, 2'd0, 1'b1};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, D0,    1'b1, 2'd0, 1'b1};
        vecs[6]  = '{1'b0, 4'b0000, 4'b0000, D0,    1'b1, 2'd0, 1'b1};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0000, D0,    1'b1, 2'd0, 1'b1};
        vecs[8]  = '{1'b0, 4'b0100, 4'b0000, D0,    1'b1, 2'd0, 1'b0};
        vecs[9]  = '{1'b0, 4'b0100, 4'b0100, D0,    1'b1, 2'd0, 1'b1};
        vecs[10] = '{1'b0, 4'b0000, 4'b0000, D2,    1'b1, 2'd2, 1'b1};
        vecs[11] = '{1'b0, 4'b0000, 4'b0000, D2,    1'b1, 2'd2, 1'b1};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, D2,    1'b1, 2'd2, 1'b1};
        vecs[13] = '{1'b0, 4'b0000, 4'b0000, D2,    1'b1, 2'd2, 1'b1};
        vecs[14] = '{1'b0, 4'b0000, 4'b0000, D2,    1'b1, 2'd2, 1'b0};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req);
            checkOutput($sformatf("vec%0d", i), vecs[i].ack, vecs[i].data,
                        vecs[i].valid, vecs[i].src, vecs[i].busy);
        end

        // Contention: sources 0,1,3 held high from reset; one grant every 5 cycles.
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3; order[3] = 2'd0;
        order[4] = 2'd1; order[5] = 2'd3; order[6] = 2'd0;
        dmap[0] = D0; dmap[1] = D1; dmap[2] = D2; dmap[3] = D3;
        applyStimulus(1'b1, 4'b0000);
        for (int c = 0; c < 32; c++) begin
            applyStimulus(1'b0, 4'b1011);
            e_ack = 4'b0000;
            if (c >= 1 && ((c - 1) % 5) == 0) begin
                e_ack[order[(c - 1) / 5]] = 1'b1;
            end
            g_done = (c >= 2) ? ((c - 2) / 5 + 1) : 0;
            e_data = (g_done > 0) ? dmap[order[g_done - 1]] : 32'h0;
            e_src  = (g_done > 0) ? order[g_done - 1] : 2'd0;
            checkOutput($sformatf("rr_c%0d", c), e_ack, e_data, (g_done > 0), e_src, (c >= 1));
        end
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 4'b0000);
            checkOutput("rr_drain", 4'b0000, D0, 1'b1, 2'd0, 1'b1);
        end
        applyStimulus(1'b0, 4'b0000);
        checkOutput("rr_idle", 4'b0000, D0, 1'b1, 2'd0, 1'b0);

        // Abort: source 1 drops req during LOAD; rr_last must stay at 0 so 1 beats 0 next.
        applyStimulus(1'b0, 4'b0010);
        checkOutput("abort_req", 4'b0000, D0, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("abort_load", 4'b0000, D0, 1'b1, 2'd0, 1'b1);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("abort_idle", 4'b0000, D0, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0011);
        checkOutput("rereq_idle", 4'b0000, D0, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0011);
        checkOutput("rereq_ack", 4'b0010, D0, 1'b1, 2'd0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 4'b0000);
            checkOutput("rereq_hold", 4'b0000, D1, 1'b1, 2'd1, 1'b1);
        end

        // Dwell: source 3 asks while source 0 is in HOLD and must wait for the window.
        applyStimulus(1'b0, 4'b0001);
        checkOutput("dwell_req0", 4'b0000, D1, 1'b1, 2'd1, 1'b0);
        applyStimulus(1'b0, 4'b0001);
        checkOutput("dwell_ack0", 4'b0001, D1, 1'b1, 2'd1, 1'b1);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("dwell_h3", 4'b0000, D0, 1'b1, 2'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b1000);
            checkOutput($sformatf("dwell_wait%0d", c), 4'b0000, D0, 1'b1, 2'd0, 1'b1);
        end
        applyStimulus(1'b0, 4'b1000);
        checkOutput("dwell_ack3", 4'b1000, D0, 1'b1, 2'd0, 1'b1);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("dwell_show3", 4'b0000, D3, 1'b1, 2'd3, 1'b1);

        // Reset while cnt=2, then a fresh request is served from IDLE.
        applyStimulus(1'b1, 4'b0000);
        checkOutput("rst_hold", 4'b0000, D3, 1'b1, 2'd3, 1'b1);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("rst_after", 4'b0000, 32'h0, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0100);
        checkOutput("rst_req2", 4'b0000, 32'h0, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 4'b0100);
        checkOutput("rst_ack2", 4'b0100, 32'h0, 1'b0, 2'd0, 1'b1);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("rst_show2", 4'b0000, D2, 1'b1, 2'd2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
